hex_to_dec: RTL and testbench
=============================

HEX_TO_DEC -- requirements
Module: hex_to_dec

Interface
REQ-001 Parameter: WIDTH, default 32, accumulator width in bits; fixed at 32 for this release.
REQ-002 Parameter: NDIG, default 10, decimal digit capacity (ceil(WIDTH*log10(2))).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-005 input_valid  input  1  input_data holds a received byte this cycle.
REQ-006 input_data  input  8  received ASCII byte.
REQ-007 output_busy  input  1  downstream transmitter cannot take a byte this cycle.
REQ-008 output_en  output  1  output_data is presented and accepted this cycle.
REQ-009 output_data  output  8  ASCII byte to transmit.

Function
REQ-010 The block SHALL parse ASCII hex numbers terminated by '\n' (0x0A) and emit each value as unsigned decimal ASCII followed by '\n'.
REQ-011 States SHALL be ACCUM, CONVERT, SKIP, SEND, SEND_NL.
REQ-012 ACCUM: input_valid with '0'-'9', 'a'-'f' or 'A'-'F' SHALL set value <= {value[WIDTH-5:0], nibble}; bits shifted out are discarded.
REQ-013 ACCUM: input_valid with '\n' SHALL latch value into the converter, clear BCD register, go to CONVERT.
REQ-014 ACCUM: any other byte SHALL be ignored with no state change.
REQ-015 Bytes arriving in CONVERT, SKIP, SEND or SEND_NL SHALL be dropped; no input backpressure exists.
REQ-016 CONVERT SHALL run double-dabble, exactly WIDTH cycles, one bit per cycle: add 3 to each BCD digit >=5, then shift left with the next value MSB.
REQ-017 Arithmetic: BCD register SHALL be 4*NDIG bits; no digit may exceed 9 after any iteration.
REQ-018 After the last CONVERT cycle, the state SHALL be SKIP with digit counter = NDIG.
REQ-019 SKIP SHALL, per cycle, while top BCD digit is 0 and counter > 1, shift BCD left 4 and decrement counter; otherwise go to SEND.
REQ-020 Value 0 SHALL therefore emit exactly one '0'.
REQ-021 SEND: when output_busy=0, output_en=1 and output_data = "0"+top digit; BCD shifts left 4, counter decrements; counter reaching 0 goes to SEND_NL.
REQ-022 SEND_NL: when output_busy=0, output_en=1 and output_data=0x0A; next state ACCUM with value cleared to 0.
REQ-023 output_en SHALL be 0 whenever output_busy=1, and in ACCUM, CONVERT and SKIP; output_en depends combinationally on output_busy.
REQ-024 output_data SHALL be 0x00 whenever output_en=0; no latches.
REQ-025 Each byte SHALL be emitted exactly once; busy stalls SHALL neither drop nor repeat bytes.
REQ-026 Latency with output_busy=0: '\n' accepted cycle N; first output_en at cycle N+33+z, where z = leading zero digits removed (0..9); subsequent bytes every cycle.
REQ-027 '\n' with no preceding digits SHALL convert the current value (0) and emit "0\n".

Reset
REQ-028 rst=0 SHALL force state ACCUM, value 0, BCD 0, counter 0, output_en 0, output_data 0x00 in any state, including mid-CONVERT or mid-SEND.
REQ-029 Output aborted by reset SHALL NOT resume; the first byte accepted after rst returns to 1 starts a fresh number.
REQ-030 rst=0 SHALL take priority over input_valid in the same cycle.

Verification
REQ-031 "ff\n", busy=0 -> "255\n"; first output_en exactly 40 cycles after '\n' cycle.
REQ-032 "\n" alone -> "0\n"; "FFFFFFFF\n" -> "4294967295\n" (z=0, first byte at N+33).
REQ-033 "123456789\n" (9 digits, truncation) -> "591751049\n"; "1x0\n" (invalid char ignored) -> "16\n".
REQ-034 "ff\n" with output_busy held 1 for 5 cycles after '2' sent -> output_en 0 for those 5 cycles, then "55\n"; total stream "255\n".
REQ-035 rst=0 for one cycle right after '2' of "255" -> output_en 0 from next cycle, no further bytes; then "a\n" -> "10\n".
REQ-036 Bytes "7\n" injected during CONVERT of "ff\n" -> output "255\n" only; next "1\n" -> "1\n".

Source files
------------

// File: rtl/hex_to_dec.sv
// hex_to_dec: ASCII hex-to-decimal line converter.
//
// Accepts ASCII hex digits, one byte at a time, and builds them into an
// accumulator. A '\n' starts a double-dabble conversion. The block then
// emits the value as unsigned decimal ASCII, with leading zeros suppressed,
// followed by '\n'.
//
// Handshake: the input side has no backpressure. A byte is consumed on every
// rising edge where input_valid=1. Bytes that arrive while a conversion or
// transmission is in progress are dropped. On the output side, a byte is
// transferred on every rising edge where output_en=1. output_en is only
// raised when output_busy=0, so output_en acts as valid and accepted at once.
// A stalled byte stays pending in the BCD register until it can be sent.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   input_valid  input_data carries a received byte this cycle
//   input_data   received ASCII byte
//   output_busy  downstream cannot take a byte this cycle
//   output_en    output_data presented and accepted this cycle
//   output_data  ASCII byte to transmit (0x00 when output_en=0)
module hex_to_dec #(
   parameter int WIDTH = 32,
   parameter int NDIG  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       input_valid,
   input  logic [7:0] input_data,
   input  logic       output_busy,
   output logic       output_en,
   output logic [7:0] output_data
);

   localparam int BW = 4 * NDIG;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      ACCUM   = 3'd0,
      CONVERT = 3'd1,
      SKIP    = 3'd2,
      SEND    = 3'd3,
      SEND_NL = 3'd4
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] value;   // hex accumulator
   logic [WIDTH-1:0] shreg;   // converter input, shifted out MSB first
   logic [BW-1:0]    bcd;     // BCD result, most significant digit on top
   logic [CW-1:0]    cnt;     // bit counter in CONVERT, digit counter after

   logic             hex_ok;
   logic [3:0]       hex_nib;
   logic [7:0]       hex_tmp;
   logic [BW-1:0]    bcd_adj;
   logic [3:0]       top_dig;

   // Double-dabble correction step: any digit of 5 or more gets +3, so that
   // the following left shift carries into the next digit correctly.
   function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < NDIG; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // ASCII hex digit decode
   always_comb begin
      hex_ok  = 1'b0;
      hex_tmp = 8'h00;
      if (input_data >= 8'h30 && input_data <= 8'h39) begin
         hex_ok  = 1'b1;
         hex_tmp = input_data - 8'h30;
      end else if (input_data >= 8'h61 && input_data <= 8'h66) begin
         hex_ok  = 1'b1;
         hex_tmp = input_data - 8'h57;
      end else if (input_data >= 8'h41 && input_data <= 8'h46) begin
         hex_ok  = 1'b1;
         hex_tmp = input_data - 8'h37;
      end
      hex_nib = hex_tmp[3:0];
   end

   always_comb begin
      bcd_adj = dd_adjust(bcd);
      top_dig = bcd[BW-1 -: 4];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ACCUM;
         value <= '0;
         shreg <= '0;
         bcd   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (input_valid) begin
                  if (input_data == 8'h0A) begin
                     shreg <= value;
                     bcd   <= '0;
                     cnt   <= '0;
                     state <= CONVERT;
                  end else if (hex_ok) begin
                     // upper nibble falls off: only the last WIDTH/4 digits count
                     value <= {value[WIDTH-5:0], hex_nib};
                  end
               end
            end
            CONVERT: begin
               bcd   <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               if (cnt == CW'(WIDTH - 1)) begin
                  cnt   <= CW'(NDIG);
                  state <= SKIP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SKIP: begin
               // Keep at least one digit so that zero prints as "0".
               if (top_dig == 4'd0 && cnt > CW'(1)) begin
                  bcd <= {bcd[BW-5:0], 4'h0};
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (!output_busy) begin
                  bcd <= {bcd[BW-5:0], 4'h0};
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state <= SEND_NL;
                  end
               end
            end
            SEND_NL: begin
               if (!output_busy) begin
                  value <= '0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   // The output is gated by rst as well as by output_busy. A byte is never
   // reported as taken in a cycle whose edge will reset the FSM.
   always_comb begin
      output_en   = 1'b0;
      output_data = 8'h00;
      if (rst && !output_busy) begin
         if (state == SEND) begin
            output_en   = 1'b1;
            output_data = 8'h30 + {4'h0, top_dig};
         end else if (state == SEND_NL) begin
            output_en   = 1'b1;
            output_data = 8'h0A;
         end
      end
   end

endmodule

// File: tb/tb_hex_to_dec.sv
// Directed testbench for hex_to_dec. Inputs are driven 1 ns after each
// rising edge. Outputs are sampled on the falling edge. cyc counts rising
// edges, so latency is measured from the edge that accepted '\n' to the
// first edge that transfers an output byte.
module tb_hex_to_dec;

   logic       clk;
   logic       rst;
   logic       input_valid;
   logic [7:0] input_data;
   logic       output_busy;
   logic       output_en;
   logic [7:0] output_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_en = -1;
   int n_edge = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   hex_to_dec #(.WIDTH(32), .NDIG(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .input_valid (input_valid),
      .input_data  (input_data),
      .output_busy (output_busy),
      .output_en   (output_en),
      .output_data (output_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   always @(negedge clk) begin
      if (output_en) begin
         rx_q.push_back(output_data);
         if (first_en < 0) first_en = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      input_valid = 1'b1;
      input_data  = b;
      @(posedge clk);
      #1;
      input_valid = 1'b0;
      input_data  = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
      end
      n_edge = cyc;   // edge on which the final byte was accepted
   endtask

   task automatic start_test();
      rx_q.delete();
      first_en = -1;
   endtask

   // scoreboard: waits for len(exp) bytes, then a few idle cycles, and then
   // compares the received stream with the expected queue
   task automatic expect_stream(input string tag, input string exp);
      int budget;
      exp_q.delete();
      for (int i = 0; i < exp.len(); i++) exp_q.push_back(exp[i]);
      budget = 0;
      while (rx_q.size() < exp_q.size() && budget < 200) begin
         @(posedge clk);
         budget++;
      end
      repeat (6) @(posedge clk);
      #1;
      check({tag, " len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp.len(); i++) begin
         if (i < rx_q.size()) check($sformatf("%s byte%0d", tag, i), rx_q[i], exp_q[i]);
      end
   endtask

   task automatic wait_first_en(input string tag);
      int budget;
      budget = 0;
      @(negedge clk);
      while (!output_en && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check({tag, " first_en seen"}, output_en, 1'b1);
   endtask

   initial begin
      rst         = 1'b0;
      input_valid = 1'b0;
      input_data  = 8'h00;
      output_busy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset output_en", output_en, 1'b0);
      check("reset output_data", output_data, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // ff -> 255, 7 leading zeros removed
      start_test();
      send_str("ff\n");
      expect_stream("ff", "255\n");
      check("ff latency", first_en - n_edge, 40);

      // bare newline -> 0
      start_test();
      send_str("\n");
      expect_stream("nl", "0\n");
      check("nl latency", first_en - n_edge, 42);

      // all ones -> full 10 digits
      start_test();
      send_str("FFFFFFFF\n");
      expect_stream("max", "4294967295\n");
      check("max latency", first_en - n_edge, 33);

      // nine digits: top nibble truncated, 0x23456789
      start_test();
      send_str("123456789\n");
      expect_stream("trunc", "591751049\n");

      // invalid char ignored
      start_test();
      send_str("1x0\n");
      expect_stream("inval", "16\n");

      // mixed case
      start_test();
      send_str("aB\n");
      expect_stream("mixed", "171\n");

      // busy stall for 5 cycles after '2'
      start_test();
      send_str("ff\n");
      wait_first_en("busy");
      check("busy first byte", output_data, 8'h32);
      @(posedge clk);
      #1;
      output_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("busy output_en", output_en, 1'b0);
         check("busy output_data", output_data, 8'h00);
         @(posedge clk);
         #1;
      end
      output_busy = 1'b0;
      expect_stream("busy", "255\n");

      // reset right after '2' aborts the output
      start_test();
      send_str("ff\n");
      wait_first_en("abort");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort output_en", output_en, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      expect_stream("abort", "2");
      start_test();
      send_str("a\n");
      expect_stream("after abort", "10\n");

      // bytes arriving during CONVERT are dropped
      start_test();
      send_str("ff\n");
      send_str("7\n");
      expect_stream("drop", "255\n");
      start_test();
      send_str("1\n");
      expect_stream("after drop", "1\n");
      check("one latency", first_en - n_edge, 42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
